// File: rtl/dyt_writeback.sv
// Writeback stage: merges ALU and load results onto one registered register-file write port.
// Loads are aligned and extended here; misaligned or reserved-size loads are dropped and flagged.
module dyt_writeback #(
  parameter int ADDR_WIDTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [1:0]            lsu_offset,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [XLEN-1:0]       w_data,
  output logic                  lsu_misaligned
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] buf_rd, buf_rd_nxt;
  logic [XLEN-1:0]       buf_data, buf_data_nxt;

  logic                  w_en_nxt, mis_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [XLEN-1:0]       w_data_nxt;

  logic                  alu_fire, lsu_fire;
  logic [4:0]            sh;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_val;
  logic                  load_bad;

  assign alu_ready = !rst && (state == EMPTY);
  assign lsu_ready = !rst && (state == EMPTY);
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  assign sh      = {lsu_offset, 3'b000};
  assign shifted = lsu_data >> sh;

  always_comb begin
    load_val = shifted;
    load_bad = 1'b0;
    case (lsu_size)
      2'b00: load_val = {{(XLEN-8){shifted[7] & !lsu_unsigned}}, shifted[7:0]};
      2'b01: begin
        load_val = {{(XLEN-16){shifted[15] & !lsu_unsigned}}, shifted[15:0]};
        load_bad = lsu_offset[0];
      end
      2'b10: begin
        load_val = lsu_data;
        load_bad = (lsu_offset != 2'b00);
      end
      default: load_bad = 1'b1;
    endcase
  end

  // Source priority: buffered ALU, then LSU, then direct ALU.
  always_comb begin
    state_nxt    = state;
    buf_rd_nxt   = buf_rd;
    buf_data_nxt = buf_data;
    w_en_nxt     = 1'b0;
    mis_nxt      = 1'b0;
    w_addr_nxt   = w_addr;
    w_data_nxt   = w_data;
    if (state == FULL) begin
      w_en_nxt   = (buf_rd != '0);
      w_addr_nxt = buf_rd;
      w_data_nxt = buf_data;
      state_nxt  = EMPTY;
    end else if (lsu_fire) begin
      if (load_bad) begin
        mis_nxt = 1'b1;
      end else begin
        w_en_nxt   = (lsu_rd != '0);
        w_addr_nxt = lsu_rd;
        w_data_nxt = load_val;
      end
      if (alu_fire) begin
        buf_rd_nxt   = alu_rd;
        buf_data_nxt = alu_data;
        state_nxt    = FULL;
      end
    end else if (alu_fire) begin
      w_en_nxt   = (alu_rd != '0);
      w_addr_nxt = alu_rd;
      w_data_nxt = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= EMPTY;
      buf_rd         <= '0;
      buf_data       <= '0;
      w_en           <= 1'b0;
      w_addr         <= '0;
      w_data         <= '0;
      lsu_misaligned <= 1'b0;
    end else begin
      state          <= state_nxt;
      buf_rd         <= buf_rd_nxt;
      buf_data       <= buf_data_nxt;
      w_en           <= w_en_nxt;
      w_addr         <= w_addr_nxt;
      w_data         <= w_data_nxt;
      lsu_misaligned <= mis_nxt;
    end
  end

endmodule
